// File: rtl/mux_n_to_1_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_to_1_reg
//  Description : Registered NUM_IN-to-1 source selector with valid/ready
//                handshake. A source is chosen either by an explicit index
//                (mode=0) or by round-robin arbitration (mode=1). The chosen
//                item is held in a single output register until the consumer
//                takes it. Back-to-back transfers run at one item per cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      data width per source (>= 1)
//    NUM_IN     number of sources (>= 2)
//    SEL_W      index width, $clog2(NUM_IN) (not overridable)
//  Ports
//    clk        clock, rising edge
//    rst        asynchronous active-high reset
//    in_data    flat source bus, source i at [i*WIDTH +: WIDTH]
//    in_valid   per-source valid
//    in_ready   per-source accept, one-hot or zero, combinational
//    mode       0 = explicit select, 1 = round-robin
//    sel        source index used when mode=0
//    out_data   registered selected data
//    out_src    index of the source held in out_data
//    out_valid  out_data holds an item not yet taken
//    out_ready  consumer takes out_data this cycle
// ============================================================================
module mux_n_to_1_reg #(
    parameter  int WIDTH  = 3,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Number of codes representable by a SEL_W-bit index. The valid vector
    // is zero-padded to this size so any sel value indexes a real bit, and
    // an out-of-range select simply reads a zero.
    localparam int              PAD_N     = 1 << SEL_W;
    // Pointer value after reset: the first round-robin search then starts
    // at source 0.
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_IN - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic [SEL_W-1:0] out_src_q,    out_src_d;
    logic             out_valid_q,  out_valid_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    // ------------------------------------------------------------------------
    // Combinational grant path
    // ------------------------------------------------------------------------
    logic [PAD_N-1:0] w_valid_pad;
    logic             w_load_ok;
    logic             w_sel_hit;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    int               w_rr_pos;
    logic             w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;

    always_comb begin
        w_valid_pad               = '0;
        w_valid_pad[NUM_IN-1:0]   = in_valid;
    end

    // The output slot is free when empty or when its item leaves this cycle.
    assign w_load_ok = !out_valid_q || out_ready;

    // Explicit select: padding bits are zero, so sel >= NUM_IN never hits.
    assign w_sel_hit = w_valid_pad[sel];

    // Round-robin: scan NUM_IN positions starting just after the last grant,
    // wrapping around; the first valid source wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_rr_pos   = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            w_rr_pos = (int'(last_grant_q) + k) % NUM_IN;
            if (!w_rr_found && w_valid_pad[SEL_W'(w_rr_pos)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SEL_W'(w_rr_pos);
            end
        end
    end

    // Reset suppresses every grant so in_ready stays low while rst is high.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        if (!rst && w_load_ok) begin
            if (mode) begin
                w_grant     = w_rr_found;
                w_grant_idx = w_rr_idx;
            end else begin
                w_grant     = w_sel_hit;
                w_grant_idx = sel;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = w_grant && (w_grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    // A grant always implies a transfer because it requires in_valid of the
    // granted source. Without a transfer, a taken item simply empties the
    // slot; data and source index keep their last values.
    always_comb begin
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (w_grant) begin
            out_data_d  = w_grant_data;
            out_src_d   = w_grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                last_grant_d = w_grant_idx;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q   <= '0;
            out_src_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LAST_RST;
        end else begin
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs come straight from flops.
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire
